// File: rtl/sram_port_arbiter_if.sv
// Request/response channel shared by the requesters and the SRAM wrapper.
//
// One instance carries one port's traffic:
//   req_addr/req_data/req_strobe/req_write/req_valid  request, master -> slave
//   req_ready                                         request accepted, slave -> master
//   rsp_data/rsp_err/rsp_valid                        response, slave -> master
//   rsp_ready                                         response accepted, master -> slave
//
// Modports:
//   master : the side issuing requests (a core port, or the arbiter toward the SRAM)
//   slave  : the side serving them (the SRAM, or the arbiter toward a core port)
interface sram_port_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  localparam int NUM_BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic [NUM_BYTES-1:0]  req_strobe;
  logic                  req_write;
  logic                  req_valid;
  logic                  req_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;
  logic                  rsp_valid;
  logic                  rsp_ready;

  modport master (
    output req_addr, req_data, req_strobe, req_write, req_valid, rsp_ready,
    input  req_ready, rsp_data, rsp_err, rsp_valid
  );

  modport slave (
    input  req_addr, req_data, req_strobe, req_write, req_valid, rsp_ready,
    output req_ready, rsp_data, rsp_err, rsp_valid
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter in front of a single-port SRAM wrapper.
// Port 0 is instruction fetch, port 1 is load/store. Requests pass through
// combinationally so the SRAM's one-cycle read latency is kept. A small FIFO
// of grant IDs remembers which port owns each in-flight request, and each
// response is steered back to that owner in grant order.
//
// Ports:
//   clk_i   clock
//   rstn_i  asynchronous active-low reset (deassertion is synchronised upstream)
//   m0, m1  slave side of the requester channels (fetch, load/store)
//   s       master side of the channel toward the SRAM wrapper
//
// Parameters:
//   DATA_WIDTH       address/data width of every port
//   MAX_OUTSTANDING  grant-ID FIFO depth, power of two, >= 1
//
// Build option:
//   SRAM_ARB_FIXED_PRIO_EN  when defined, port 1 always wins a tie (fixed
//                           priority); otherwise ties alternate round-robin.
module sram_port_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  sram_port_arbiter_if.slave  m0,
  sram_port_arbiter_if.slave  m1,
  sram_port_arbiter_if.master s
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int PTR_W     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W     = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

  logic                  winner;     // 0 = port 0, 1 = port 1
  logic                  any_valid;
  logic                  grant;
  logic                  pop;
  logic                  has_out;
  logic                  head;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  id_mem [MAX_OUTSTANDING];
  logic [DATA_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_data;
  logic [NUM_BYTES-1:0]  win_strobe;
  logic                  win_write;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Winner selection. With a single valid port, winner = m1.req_valid already
  // names it; with no valid port it falls to 0 so port 0's fields are driven.
  // ---------------------------------------------------------------------------
`ifdef SRAM_ARB_FIXED_PRIO_EN
  assign winner = m1.req_valid;
`else
  logic last_grant;

  always_comb begin
    // NOTE: assign a default before any condition so every path drives
    // winner; a path that leaves it unassigned would infer a latch.
    winner = m1.req_valid;
    if (m0.req_valid && m1.req_valid) begin
      winner = ~last_grant;
    end
  end

  // Reset to 1 so port 0 wins the first tie.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      last_grant <= 1'b1;
    end else if (grant) begin
      last_grant <= winner;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Request path
  // ---------------------------------------------------------------------------
  assign any_valid = m0.req_valid | m1.req_valid;
  // A full FIFO blocks the grant even when a response pops this same cycle.
  assign grant     = rstn_i && s.req_ready && (count != FULL_CNT) && any_valid;

  assign win_addr   = winner ? m1.req_addr   : m0.req_addr;
  assign win_data   = winner ? m1.req_data   : m0.req_data;
  assign win_strobe = winner ? m1.req_strobe : m0.req_strobe;
  assign win_write  = winner ? m1.req_write  : m0.req_write;

  assign s.req_addr   = win_addr;
  assign s.req_data   = win_data;
  assign s.req_strobe = win_strobe;
  assign s.req_write  = win_write;
  assign s.req_valid  = grant;

  assign m0.req_ready = grant && !winner;
  assign m1.req_ready = grant &&  winner;

  // ---------------------------------------------------------------------------
  // Response path. Data and error are broadcast; only valid is steered.
  // With nothing outstanding the response is spurious and is drained.
  // ---------------------------------------------------------------------------
  assign has_out = (count != '0);
  assign head    = id_mem[rd_ptr];

  assign m0.rsp_data  = s.rsp_data;
  assign m1.rsp_data  = s.rsp_data;
  assign m0.rsp_err   = s.rsp_err;
  assign m1.rsp_err   = s.rsp_err;
  assign m0.rsp_valid = rstn_i && has_out && !head && s.rsp_valid;
  assign m1.rsp_valid = rstn_i && has_out &&  head && s.rsp_valid;
  assign s.rsp_ready  = rstn_i && (has_out ? (head ? m1.rsp_ready : m0.rsp_ready) : 1'b1);

  assign pop = s.rsp_valid && s.rsp_ready && has_out;

  // ---------------------------------------------------------------------------
  // Grant-ID FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rstn_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // here samples the pre-edge values, independent of statement order.
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (grant) wr_ptr <= next_ptr(wr_ptr);
      if (pop)   rd_ptr <= next_ptr(rd_ptr);
      case ({grant, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the ID storage is deliberately not reset; an entry is only read
  // while count > 0, which guarantees it was written after the last reset.
  always_ff @(posedge clk_i) begin
    if (grant) begin
      id_mem[wr_ptr] <= winner;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter.
// A behavioural SRAM (one-cycle latency, holds its response until accepted)
// sits on the s channel. Every grant seen on a requester port pushes the
// expected response (owner port, data from a reference memory, error flag)
// into a scoreboard; every response cycle is checked against its head.
// A vector table exercises arbitration cycle by cycle, followed by
// hand-written sequences for write/read, errors, back-pressure and reset.
module tb_sram_port_arbiter;

`ifdef SRAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk;
  logic rstn;

  sram_port_arbiter_if #(.DATA_WIDTH(32)) m0_if ();
  sram_port_arbiter_if #(.DATA_WIDTH(32)) m1_if ();
  sram_port_arbiter_if #(.DATA_WIDTH(32)) s_if ();

  sram_port_arbiter #(
    .DATA_WIDTH      (32),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .m0     (m0_if.slave),
    .m1     (m1_if.slave),
    .s      (s_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, 32'(act), 32'(exp));
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural SRAM on the s channel
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic [31:0] sram [64];
  rsp_t        mem_q [$];
  bit          mem_init_done = 1'b0;

  function automatic logic [31:0] init_word(input int idx);
    return (idx == 8) ? 32'h0 : (32'hA500_0000 | 32'(idx));
  endfunction

  always @(posedge clk) begin
    rsp_t r;
    if (!mem_init_done) begin
      for (int i = 0; i < 64; i++) sram[i] <= init_word(i);
      mem_init_done <= 1'b1;
    end
    if (s_if.rsp_valid && s_if.rsp_ready) void'(mem_q.pop_front());
    if (s_if.req_valid && s_if.req_ready) begin
      r.err  = (s_if.req_addr >= 32'h100);
      r.data = 32'h0;
      if (!r.err) begin
        if (s_if.req_write) begin
          for (int b = 0; b < 4; b++)
            if (s_if.req_strobe[b]) sram[s_if.req_addr[7:2]][8*b +: 8] <= s_if.req_data[8*b +: 8];
        end else begin
          r.data = sram[s_if.req_addr[7:2]];
        end
      end
      mem_q.push_back(r);
    end
    s_if.rsp_valid <= (mem_q.size() != 0);
    if (mem_q.size() != 0) begin
      s_if.rsp_data <= mem_q[0].data;
      s_if.rsp_err  <= mem_q[0].err;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard with its own reference memory
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          port;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] ref_mem [64];

  task automatic sb_push(input bit port, input logic write, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strobe);
    exp_t e;
    e.port = port;
    e.err  = (addr >= 32'h100);
    e.data = 32'h0;
    if (!e.err) begin
      if (write) begin
        for (int b = 0; b < 4; b++)
          if (strobe[b]) ref_mem[addr[7:2]][8*b +: 8] = data[8*b +: 8];
      end else begin
        e.data = ref_mem[addr[7:2]];
      end
    end
    sb.push_back(e);
  endtask

  // Response checks use the scoreboard head from before this cycle's grants.
  task automatic monitor();
    exp_t e;
    bit   exp_ready;
    if (!rstn) return;
    check_bit("single_grant", m0_if.req_ready && m1_if.req_ready, 1'b0);
    if (s_if.rsp_valid) begin
      if (sb.size() == 0) begin
        check_bit("spur_m0_rsp_valid", m0_if.rsp_valid, 1'b0);
        check_bit("spur_m1_rsp_valid", m1_if.rsp_valid, 1'b0);
        check_bit("spur_s_rsp_ready", s_if.rsp_ready, 1'b1);
      end else begin
        e = sb[0];
        exp_ready = e.port ? m1_if.rsp_ready : m0_if.rsp_ready;
        check_bit("rsp_m0_valid", m0_if.rsp_valid, !e.port);
        check_bit("rsp_m1_valid", m1_if.rsp_valid, e.port);
        check_bit("rsp_s_ready", s_if.rsp_ready, exp_ready);
        if (exp_ready) begin
          check("rsp_data", e.port ? m1_if.rsp_data : m0_if.rsp_data, e.data);
          check_bit("rsp_err", e.port ? m1_if.rsp_err : m0_if.rsp_err, e.err);
          void'(sb.pop_front());
        end
      end
    end else begin
      check_bit("idle_m0_rsp_valid", m0_if.rsp_valid, 1'b0);
      check_bit("idle_m1_rsp_valid", m1_if.rsp_valid, 1'b0);
    end
    if (m0_if.req_valid && m0_if.req_ready)
      sb_push(1'b0, m0_if.req_write, m0_if.req_addr, m0_if.req_data, m0_if.req_strobe);
    if (m1_if.req_valid && m1_if.req_ready)
      sb_push(1'b1, m1_if.req_write, m1_if.req_addr, m1_if.req_data, m1_if.req_strobe);
  endtask

  // ---------------------------------------------------------------------------
  // Drivers: inputs change on the falling edge, outputs sampled 1 time unit later
  // ---------------------------------------------------------------------------
  task automatic set_m0(input bit v, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] st);
    m0_if.req_valid = v; m0_if.req_write = w; m0_if.req_addr = a;
    m0_if.req_data = d; m0_if.req_strobe = st;
  endtask

  task automatic set_m1(input bit v, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] st);
    m1_if.req_valid = v; m1_if.req_write = w; m1_if.req_addr = a;
    m1_if.req_data = d; m1_if.req_strobe = st;
  endtask

  task automatic idle_all();
    set_m0(1'b0, 1'b0, 32'h10, 32'h0, 4'hF);
    set_m1(1'b0, 1'b0, 32'h24, 32'h0, 4'hF);
  endtask

  task automatic settle();
    #1;
    monitor();
  endtask

  task automatic advance();
    @(negedge clk);
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle_all();
    sb.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Arbitration vectors (applied on consecutive cycles from reset)
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          m0_valid;
    bit          m1_valid;
    bit          mem_ready;
    bit          exp_m0_ready;
    bit          exp_m1_ready;
    bit          exp_s_valid;
    logic [31:0] exp_addr;
  } vec_t;

  // win names the port the arbiter must pick for this row's inputs.
  function automatic vec_t row(input bit v0, input bit v1, input bit rdy, input bit win);
    vec_t r;
    r.m0_valid     = v0;
    r.m1_valid     = v1;
    r.mem_ready    = rdy;
    r.exp_s_valid  = rdy && (v0 || v1);
    r.exp_m0_ready = r.exp_s_valid && !win;
    r.exp_m1_ready = r.exp_s_valid && win;
    r.exp_addr     = win ? 32'h24 : 32'h10;
    return r;
  endfunction

  vec_t vecs [12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_rdy [6];
    bit rsp_rdy [6];
    int grants;

    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

    rstn = 1'b0;
    idle_all();
    m0_if.rsp_ready = 1'b1;
    m1_if.rsp_ready = 1'b1;
    s_if.req_ready  = 1'b1;

    // --- outputs held quiet during reset, even with requests pending ---
    @(negedge clk);
    set_m0(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    set_m1(1'b1, 1'b0, 32'h24, 32'h0, 4'hF);
    settle();
    check_bit("rst_m0_req_ready", m0_if.req_ready, 1'b0);
    check_bit("rst_m1_req_ready", m1_if.req_ready, 1'b0);
    check_bit("rst_s_req_valid", s_if.req_valid, 1'b0);
    check_bit("rst_m0_rsp_valid", m0_if.rsp_valid, 1'b0);
    check_bit("rst_m1_rsp_valid", m1_if.rsp_valid, 1'b0);
    check_bit("rst_s_rsp_ready", s_if.rsp_ready, 1'b0);
    check("rst_count", 32'(dut.count), 32'd0);
    advance();
    do_reset();

    // --- single m0 read right after reset ---
    set_m0(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    settle();
    check_bit("first_m0_req_ready", m0_if.req_ready, 1'b1);
    check_bit("first_s_req_valid", s_if.req_valid, 1'b1);
    check("first_s_req_addr", s_if.req_addr, 32'h10);
    advance();
    idle_all();
    settle();
    check_bit("first_m0_rsp_valid", m0_if.rsp_valid, 1'b1);
    check("first_m0_rsp_data", m0_if.rsp_data, 32'hA500_0004);
    check_bit("first_m1_rsp_valid", m1_if.rsp_valid, 1'b0);
    advance();

    // --- arbitration table ---
    do_reset();
    vecs[0]  = row(1'b0, 1'b0, 1'b1, 1'b0);
    vecs[1]  = row(1'b1, 1'b1, 1'b1, FIXED ? 1'b1 : 1'b0);
    vecs[2]  = row(1'b1, 1'b1, 1'b1, 1'b1);
    vecs[3]  = row(1'b1, 1'b1, 1'b1, FIXED ? 1'b1 : 1'b0);
    vecs[4]  = row(1'b1, 1'b1, 1'b1, 1'b1);
    vecs[5]  = row(1'b0, 1'b1, 1'b1, 1'b1);
    vecs[6]  = row(1'b1, 1'b1, 1'b0, FIXED ? 1'b1 : 1'b0);
    vecs[7]  = row(1'b1, 1'b1, 1'b1, FIXED ? 1'b1 : 1'b0);
    vecs[8]  = row(1'b0, 1'b1, 1'b0, 1'b1);
    vecs[9]  = row(1'b1, 1'b1, 1'b1, 1'b1);
    vecs[10] = row(1'b0, 1'b0, 1'b1, 1'b0);
    vecs[11] = row(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      set_m0(vecs[i].m0_valid, 1'b0, 32'h10, 32'h0, 4'hF);
      set_m1(vecs[i].m1_valid, 1'b0, 32'h24, 32'h0, 4'hF);
      s_if.req_ready = vecs[i].mem_ready;
      settle();
      check_bit($sformatf("vec%0d_m0_req_ready", i), m0_if.req_ready, vecs[i].exp_m0_ready);
      check_bit($sformatf("vec%0d_m1_req_ready", i), m1_if.req_ready, vecs[i].exp_m1_ready);
      check_bit($sformatf("vec%0d_s_req_valid", i), s_if.req_valid, vecs[i].exp_s_valid);
      check($sformatf("vec%0d_s_req_addr", i), s_if.req_addr, vecs[i].exp_addr);
      advance();
    end
    idle_all();
    s_if.req_ready = 1'b1;
    repeat (2) tick();

    // --- byte-strobed write from m1, read back by m0 ---
    set_m1(1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, 4'b0011);
    settle();
    check_bit("wr_m1_req_ready", m1_if.req_ready, 1'b1);
    check_bit("wr_s_req_write", s_if.req_write, 1'b1);
    check("wr_s_req_strobe", 32'(s_if.req_strobe), 32'h3);
    check("wr_s_req_data", s_if.req_data, 32'hDEAD_BEEF);
    advance();
    idle_all();
    set_m0(1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
    settle();
    check_bit("rd_m0_req_ready", m0_if.req_ready, 1'b1);
    advance();
    idle_all();
    settle();
    check_bit("rd_m0_rsp_valid", m0_if.rsp_valid, 1'b1);
    check("rd_m0_rsp_data", m0_if.rsp_data, 32'h0000_BEEF);
    advance();

    // --- out-of-range read: error broadcast, valid only to m1 ---
    set_m1(1'b1, 1'b0, 32'h200, 32'h0, 4'hF);
    tick();
    idle_all();
    settle();
    check_bit("err_m1_rsp_valid", m1_if.rsp_valid, 1'b1);
    check_bit("err_m1_rsp_err", m1_if.rsp_err, 1'b1);
    check_bit("err_m0_rsp_err", m0_if.rsp_err, 1'b1);
    check_bit("err_m0_rsp_valid", m0_if.rsp_valid, 1'b0);
    advance();

    // --- back-pressure fills the grant FIFO ---
    do_reset();
    exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    rsp_rdy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    grants = 0;
    set_m0(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    for (int c = 0; c < 6; c++) begin
      m0_if.rsp_ready = rsp_rdy[c];
      settle();
      check_bit($sformatf("bp%0d_m0_req_ready", c), m0_if.req_ready, exp_rdy[c]);
      if (m0_if.req_ready) grants++;
      if (c == 2) check("bp_count_full", 32'(dut.count), 32'd2);
      if (c == 3) check("bp_grants", 32'(grants), 32'd2);
      advance();
    end
    idle_all();
    m0_if.rsp_ready = 1'b1;
    repeat (2) tick();

    // --- reset while a request is in flight ---
    do_reset();
    set_m0(1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
    tick();
    idle_all();
    rstn = 1'b0;
    sb.delete();
    settle();
    check_bit("mid_rst_m0_rsp_valid", m0_if.rsp_valid, 1'b0);
    check_bit("mid_rst_m1_rsp_valid", m1_if.rsp_valid, 1'b0);
    check("mid_rst_count", 32'(dut.count), 32'd0);
    advance();
    rstn = 1'b1;
    settle();
    check_bit("post_rst_m0_rsp_valid", m0_if.rsp_valid, 1'b0);
    check_bit("post_rst_m1_rsp_valid", m1_if.rsp_valid, 1'b0);
    check_bit("post_rst_s_rsp_ready", s_if.rsp_ready, 1'b1);
    check("post_rst_count", 32'(dut.count), 32'd0);
    advance();
    set_m0(1'b1, 1'b0, 32'h14, 32'h0, 4'hF);
    settle();
    check_bit("post_rst_m0_req_ready", m0_if.req_ready, 1'b1);
    advance();
    idle_all();
    settle();
    check_bit("post_rst_m0_rsp_valid2", m0_if.rsp_valid, 1'b1);
    check("post_rst_m0_rsp_data", m0_if.rsp_data, 32'hA500_0005);
    advance();
    repeat (2) tick();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
